random_spawner: RTL
===================

RANDOM_SPAWNER -- requirements
Module: random_spawner

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  SIZE_BITS, 8, width of the random value
  FRAMES_PER_SPAWN, 60, startOfFrame pulses between spawns
  NUM_LANES, 5, number of spawn lanes (1..8)
  LANE_WIDTH, 128, pixel pitch between lanes
  X_OFFSET, 32, pixel x of lane 0
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  in  1  system clock
  reset  in  1  synchronous, active-high reset
  startOfFrame  in  1  one-cycle pulse per video frame
  enable  in  1  spawning permitted
  rnd_rise  out  1  request pulse to the random generator
  rnd_dout  in  SIZE_BITS  random value returned by the generator
  spawn_valid  out  1  spawn offer valid
  spawn_ready  in  1  consumer accepts the offer
  spawn_lane  out  3  selected lane
  spawn_x  out  11  pixel x of the selected lane
  spawn_count  out  8  accepted spawns, wraps 255->0
REQ-003 The design SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, WAIT, REQ, LATCH, SAMPLE and OFFER.
REQ-005 IDLE->WAIT SHALL occur when enable=1; the frame counter SHALL be cleared on entry to WAIT.
REQ-006 In WAIT, each startOfFrame SHALL increment the frame counter; a pulse arriving while count=FRAMES_PER_SPAWN-1 SHALL move the FSM to REQ.
REQ-007 In WAIT, enable=0 SHALL return the FSM to IDLE and clear the frame counter.
REQ-008 rnd_rise SHALL be a registered output, high for exactly one cycle, in REQ; it SHALL be 0 in every other state.
REQ-009 REQ->LATCH->SAMPLE SHALL take one cycle each; in SAMPLE, rnd_dout SHALL be captured into an internal register (generator latency is 1 clock after it samples the rise).
REQ-010 Lane mapping SHALL be lane = (rnd * NUM_LANES) >> SIZE_BITS; the product SHALL be at least SIZE_BITS+3 bits wide, so the result is always < NUM_LANES.
REQ-011 spawn_x SHALL be X_OFFSET + lane*LANE_WIDTH, computed in 11 bits.
REQ-012 SAMPLE->OFFER SHALL occur after one cycle, with spawn_lane and spawn_x registered.
REQ-013 In OFFER, spawn_valid=1 and spawn_lane/spawn_x SHALL stay stable until a cycle with spawn_ready=1.
REQ-014 On the handshake cycle, the FSM SHALL increment spawn_count, record the lane as last_lane, and go to WAIT if enable=1, otherwise to IDLE.
REQ-015 Deasserting enable SHALL NOT abort REQ, LATCH, SAMPLE or OFFER; the current spawn SHALL complete.
REQ-016 startOfFrame SHALL be ignored outside WAIT; frames are not accumulated.
REQ-017 With FRAMES_PER_SPAWN=1, every startOfFrame seen in WAIT SHALL trigger REQ.

Reset
REQ-018 Reset SHALL force: state=IDLE; frame counter=0; rnd_rise=0; spawn_valid=0; spawn_lane=0; spawn_x=X_OFFSET; spawn_count=0; last_lane=NUM_LANES-1.
REQ-019 Reset asserted in any state, including mid-OFFER, SHALL take effect at the next clk edge, dropping any pending offer.

Configuration
REQ-020 With macro SPAWN_NO_REPEAT_EN defined, a mapped lane equal to last_lane SHALL be replaced by (lane+1) mod NUM_LANES before OFFER, with no extra latency.
REQ-021 Without SPAWN_NO_REPEAT_EN, the mapped lane SHALL be used unchanged, and last_lane logic MAY be omitted.

Verification
REQ-022 Reset, enable=1, FRAMES_PER_SPAWN=3, three startOfFrame pulses -> single 1-cycle rnd_rise after the 3rd pulse; spawn_valid 3 cycles later.
REQ-023 rnd_dout=128, NUM_LANES=5 -> spawn_lane=2, spawn_x=288; rnd_dout=255 -> lane 4, x=544; rnd_dout=0 -> lane 0, x=32.
REQ-024 spawn_ready held 0 for 10 cycles, then 1 -> spawn_valid/spawn_x stable for 10 cycles; spawn_count increments by exactly 1; spawn_valid=0 next cycle.
REQ-025 Two consecutive spawns with rnd_dout=128 -> lanes 2 then 3 (x=416) with SPAWN_NO_REPEAT_EN; lanes 2 then 2 without it.
REQ-026 enable dropped in WAIT -> IDLE, no rnd_rise; enable dropped in OFFER -> offer completes, then IDLE; reset in OFFER -> spawn_valid=0 next cycle, spawn_count=0.

Source files
------------

// File: rtl/random_spawner.sv
// Frame-paced spawn generator: every FRAMES_PER_SPAWN frames it requests a random
// value, maps it to a lane and offers the lane on a valid/ready handshake.
// Optional macro SPAWN_NO_REPEAT_EN bumps a lane that repeats the previous accepted one.
module random_spawner #(
  parameter int SIZE_BITS        = 8,
  parameter int FRAMES_PER_SPAWN = 60,
  parameter int NUM_LANES        = 5,
  parameter int LANE_WIDTH       = 128,
  parameter int X_OFFSET         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 enable,
  output logic                 rnd_rise,
  input  logic [SIZE_BITS-1:0] rnd_dout,
  output logic                 spawn_valid,
  input  logic                 spawn_ready,
  output logic [2:0]           spawn_lane,
  output logic [10:0]          spawn_x,
  output logic [7:0]           spawn_count
);

  localparam int CW = (FRAMES_PER_SPAWN > 1) ? $clog2(FRAMES_PER_SPAWN) : 1;
  localparam int PW = SIZE_BITS + 4;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_LATCH, S_SAMPLE, S_OFFER
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_frames;
  logic            r_rnd_rise;
  logic            r_spawn_valid;
  logic [2:0]      r_spawn_lane;
  logic [10:0]     r_spawn_x;
  logic [7:0]      r_spawn_count;
  logic [PW-1:0]   w_prod;
  logic [2:0]      w_map;
  logic [2:0]      w_lane;
  logic [10:0]     w_x;
  logic            w_hs;
  logic            w_frame_tc;

  // Scaled-multiply lane mapping keeps the result strictly below NUM_LANES.
  assign w_prod = PW'(rnd_dout) * PW'(NUM_LANES);
  assign w_map  = 3'(w_prod >> SIZE_BITS);

`ifdef SPAWN_NO_REPEAT_EN
  logic [2:0] r_last_lane;

  always_comb begin
    w_lane = w_map;
    if (w_map == r_last_lane)
      w_lane = (w_map == 3'(NUM_LANES - 1)) ? 3'd0 : w_map + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_last_lane <= 3'(NUM_LANES - 1);
    else if (w_hs)
      r_last_lane <= r_spawn_lane;
  end
`else
  assign w_lane = w_map;
`endif

  assign w_x        = 11'(X_OFFSET) + 11'(LANE_WIDTH) * {8'd0, w_lane};
  assign w_hs       = (r_state == S_OFFER) && spawn_ready;
  assign w_frame_tc = (r_frames == CW'(FRAMES_PER_SPAWN - 1));

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_WAIT;
      S_WAIT: begin
        if (!enable)
          w_next = S_IDLE;
        else if (startOfFrame && w_frame_tc)
          w_next = S_REQ;
      end
      S_REQ:    w_next = S_LATCH;
      S_LATCH:  w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_OFFER;
      S_OFFER:  if (spawn_ready) w_next = enable ? S_WAIT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frames      <= '0;
      r_rnd_rise    <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_lane  <= 3'd0;
      r_spawn_x     <= 11'(X_OFFSET);
      r_spawn_count <= 8'd0;
    end else begin
      r_rnd_rise    <= (w_next == S_REQ);
      r_spawn_valid <= (w_next == S_OFFER);
      // Held at zero outside WAIT so every entry into WAIT starts a fresh count.
      if (r_state != S_WAIT)
        r_frames <= '0;
      else if (startOfFrame)
        r_frames <= r_frames + CW'(1);
      if (r_state == S_SAMPLE) begin
        r_spawn_lane <= w_lane;
        r_spawn_x    <= w_x;
      end
      if (w_hs)
        r_spawn_count <= r_spawn_count + 8'd1;
    end
  end

  assign rnd_rise    = r_rnd_rise;
  assign spawn_valid = r_spawn_valid;
  assign spawn_lane  = r_spawn_lane;
  assign spawn_x     = r_spawn_x;
  assign spawn_count = r_spawn_count;

endmodule
